// File: rtl/rob_commit_if.sv
// Port bundle between rename, writeback and the reorder buffer.
// The master drives allocate/writeback requests; the slave (ROB) returns tags, status and commit groups.
interface rob_commit_if #(
  parameter int TAG_W  = 4,
  parameter int PREG_W = 6
);
  logic [3:0]          alloc_valid;
  logic                alloc_ready;
  logic [3:0]          alloc_wen;
  logic [19:0]         alloc_rd;
  logic [4*PREG_W-1:0] alloc_prd;
  logic [4*PREG_W-1:0] alloc_preprd;
  logic [4*TAG_W-1:0]  alloc_tag;

  logic [3:0]          wb_valid;
  logic [4*TAG_W-1:0]  wb_tag;

  logic [3:0]          cmt_valid;
  logic [3:0]          cmt_wen;
  logic [19:0]         cmt_rd;
  logic [4*PREG_W-1:0] cmt_prd;
  logic [4*PREG_W-1:0] cmt_preprd;
  logic [TAG_W:0]      rob_count;
  logic                rob_empty;

  modport master (
    output alloc_valid, alloc_wen, alloc_rd, alloc_prd, alloc_preprd, wb_valid, wb_tag,
    input  alloc_ready, alloc_tag, cmt_valid, cmt_wen, cmt_rd, cmt_prd, cmt_preprd,
           rob_count, rob_empty
  );

  modport slave (
    input  alloc_valid, alloc_wen, alloc_rd, alloc_prd, alloc_preprd, wb_valid, wb_tag,
    output alloc_ready, alloc_tag, cmt_valid, cmt_wen, cmt_rd, cmt_prd, cmt_preprd,
           rob_count, rob_empty
  );
endinterface

// File: rtl/rob_commit.sv
// 16-entry reorder buffer: 4-wide allocate, 4 writeback ports, in-order retire of up to 4 per cycle.
// Retired groups carry the old physical destination so the free list can reclaim it.
module rob_commit #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int PREG_W = 6
) (
  input logic         clk,
  input logic         rst,
  rob_commit_if.slave rob
);
  localparam logic [TAG_W:0] ALLOC_MAX_COUNT = (TAG_W+1)'(DEPTH - 4);

  logic [DEPTH-1:0]    ent_valid;
  logic [DEPTH-1:0]    ent_done;
  logic [DEPTH-1:0]    ent_wen;
  logic [4:0]          ent_rd     [DEPTH];
  logic [PREG_W-1:0]   ent_prd    [DEPTH];
  logic [PREG_W-1:0]   ent_preprd [DEPTH];

  logic [TAG_W:0]      head;
  logic [TAG_W:0]      tail;
  logic [TAG_W:0]      count;
  logic [TAG_W-1:0]    head_idx [4];
  logic [TAG_W-1:0]    tail_idx [4];
  logic                alloc_fire;
  logic [2:0]          alloc_num;
  logic [2:0]          cmt_num;
  logic                cmt_run;
  logic [3:0]          cmt_mask;

  logic [3:0]          cmt_valid_q;
  logic [3:0]          cmt_wen_q;
  logic [19:0]         cmt_rd_q;
  logic [4*PREG_W-1:0] cmt_prd_q;
  logic [4*PREG_W-1:0] cmt_preprd_q;

  // Pointers carry a wrap bit so full (count==DEPTH) and empty are distinct.
  assign count           = tail - head;
  assign rob.rob_count   = count;
  assign rob.rob_empty   = (count == '0);
  assign rob.alloc_ready = (count <= ALLOC_MAX_COUNT);
  assign alloc_fire      = (rob.alloc_valid != 4'b0000) && rob.alloc_ready;

  assign rob.cmt_valid   = cmt_valid_q;
  assign rob.cmt_wen     = cmt_wen_q;
  assign rob.cmt_rd      = cmt_rd_q;
  assign rob.cmt_prd     = cmt_prd_q;
  assign rob.cmt_preprd  = cmt_preprd_q;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      head_idx[i] = head[TAG_W-1:0] + TAG_W'(i);
      tail_idx[i] = tail[TAG_W-1:0] + TAG_W'(i);
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_tag
    assign rob.alloc_tag[g*TAG_W +: TAG_W] = tail_idx[g];
  end

  always_comb begin
    alloc_num = 3'd0;
    for (int i = 0; i < 4; i++) begin
      alloc_num = alloc_num + {2'b00, rob.alloc_valid[i]};
    end
  end

  // Retire the leading run of completed entries; free slots are never valid, so the run stops at tail.
  always_comb begin
    cmt_num = 3'd0;
    cmt_run = 1'b1;
    for (int j = 0; j < 4; j++) begin
      cmt_run = cmt_run && ent_valid[head_idx[j]] && ent_done[head_idx[j]];
      if (cmt_run) begin
        cmt_num = cmt_num + 3'd1;
      end
    end
    cmt_mask = 4'((5'd1 << cmt_num) - 5'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      ent_valid    <= '0;
      ent_done     <= '0;
      cmt_valid_q  <= '0;
      cmt_wen_q    <= '0;
      cmt_rd_q     <= '0;
      cmt_prd_q    <= '0;
      cmt_preprd_q <= '0;
    end else begin
      for (int p = 0; p < 4; p++) begin
        if (rob.wb_valid[p] && ent_valid[rob.wb_tag[p*TAG_W +: TAG_W]]) begin
          ent_done[rob.wb_tag[p*TAG_W +: TAG_W]] <= 1'b1;
        end
      end

      // Committing entries are cleared after writeback so a late strobe cannot leave stale done bits.
      for (int j = 0; j < 4; j++) begin
        if (cmt_mask[j]) begin
          ent_valid[head_idx[j]]        <= 1'b0;
          ent_done[head_idx[j]]         <= 1'b0;
          cmt_wen_q[j]                  <= ent_wen[head_idx[j]];
          cmt_rd_q[5*j +: 5]            <= ent_rd[head_idx[j]];
          cmt_prd_q[j*PREG_W +: PREG_W] <= ent_prd[head_idx[j]];
          cmt_preprd_q[j*PREG_W +: PREG_W] <= ent_preprd[head_idx[j]];
        end else begin
          cmt_wen_q[j]                  <= 1'b0;
          cmt_rd_q[5*j +: 5]            <= 5'd0;
          cmt_prd_q[j*PREG_W +: PREG_W] <= '0;
          cmt_preprd_q[j*PREG_W +: PREG_W] <= '0;
        end
      end
      cmt_valid_q <= cmt_mask;
      head        <= head + (TAG_W+1)'(cmt_num);

      if (alloc_fire) begin
        for (int i = 0; i < 4; i++) begin
          if (rob.alloc_valid[i]) begin
            ent_valid[tail_idx[i]] <= 1'b1;
            ent_done[tail_idx[i]]  <= 1'b0;
          end
        end
        tail <= tail + (TAG_W+1)'(alloc_num);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (rob.alloc_valid[i]) begin
          ent_wen[tail_idx[i]]    <= rob.alloc_wen[i];
          ent_rd[tail_idx[i]]     <= rob.alloc_rd[5*i +: 5];
          ent_prd[tail_idx[i]]    <= rob.alloc_prd[i*PREG_W +: PREG_W];
          ent_preprd[tail_idx[i]] <= rob.alloc_preprd[i*PREG_W +: PREG_W];
        end
      end
    end
  end
endmodule
